rob_retire: RTL and testbench

- 2-wide in-order retire stage (reorder buffer) for the out-of-order RV32 core.
- Sits at the opposite end of the rename stage. It accepts up to two renamed instructions per cycle in program order and records each one's new and previous physical destination.
- Marks entries complete from two writeback ports.
- Retires up to two completed instructions per cycle from the head, in order. For each retired instruction it returns the previous physical register (old_pd) to rename's free pool via rt_flag_1/fp_i_1 and rt_flag_2/fp_i_2.

---
 rtl/rob_retire.sv | 160 ++++++++++++++++
 tb/tb_rob_retire.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// rob_retire: 2-wide in-order retire stage (reorder buffer).
// Accepts up to two renamed instructions per cycle in program order, marks
// entries complete from two writeback ports, and retires up to two completed
// instructions per cycle from the head, returning each retired instruction's
// previous physical destination to the rename free pool.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en_1,
    input  logic              alloc_has_rd_1,
    input  logic [PREG_W-1:0] alloc_pd_1,
    input  logic [PREG_W-1:0] alloc_old_pd_1,
    input  logic              alloc_en_2,
    input  logic              alloc_has_rd_2,
    input  logic [PREG_W-1:0] alloc_pd_2,
    input  logic [PREG_W-1:0] alloc_old_pd_2,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  rob_idx_1,
    output logic [IDX_W-1:0]  rob_idx_2,
    input  logic              cmpl_en_a,
    input  logic [IDX_W-1:0]  cmpl_idx_a,
    input  logic              cmpl_en_b,
    input  logic [IDX_W-1:0]  cmpl_idx_b,
    output logic              rt_flag_1,
    output logic [PREG_W-1:0] fp_i_1,
    output logic              rt_flag_2,
    output logic [PREG_W-1:0] fp_i_2,
    output logic [1:0]        retire_cnt,
    output logic [IDX_W:0]    count
);

    // Per-entry state
    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0]             r_done;
    logic [DEPTH-1:0]             r_has_rd;
    logic [DEPTH-1:0][PREG_W-1:0] r_pd;
    logic [DEPTH-1:0][PREG_W-1:0] r_old_pd;

    // Pointers and occupancy
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    // Registered retire outputs
    logic              r_rt_flag_1;
    logic              r_rt_flag_2;
    logic [PREG_W-1:0] r_fp_i_1;
    logic [PREG_W-1:0] r_fp_i_2;
    logic [1:0]        r_retire_cnt;

    logic [IDX_W-1:0] w_head_p1;
    logic [IDX_W-1:0] w_tail_p1;
    logic             w_ready;
    logic             w_acc1;
    logic             w_acc2;
    logic             w_r1;
    logic             w_r2;
    logic             w_free1;
    logic             w_free2;
    logic [IDX_W:0]   w_count_nxt;

    // The new pd is kept with each entry for debug/recovery visibility; no
    // logic in this stage consumes it.
    logic w_unused_pd;
    assign w_unused_pd = ^r_pd;

    // Allocation acceptance, retire selection and next occupancy
    always_comb begin
        w_head_p1 = r_head + IDX_W'(1);
        w_tail_p1 = r_tail + IDX_W'(1);
        w_ready   = (r_count <= (IDX_W+1)'(DEPTH - 2));
        w_acc1    = alloc_en_1 & w_ready;
        w_acc2    = w_acc1 & alloc_en_2;
        w_r1      = r_valid[r_head] & r_done[r_head];
        // head+1 is only a candidate when it lies before the tail
        w_r2      = w_r1 & (r_count >= (IDX_W+1)'(2))
                  & r_valid[w_head_p1] & r_done[w_head_p1];
        w_free1   = w_r1 & r_has_rd[r_head];
        w_free2   = w_r2 & r_has_rd[w_head_p1];
        w_count_nxt = r_count + (IDX_W+1)'(w_acc1) + (IDX_W+1)'(w_acc2)
                    - (IDX_W+1)'(w_r1) - (IDX_W+1)'(w_r2);
    end

    // Output drive
    always_comb begin
        alloc_ready = w_ready;
        rob_idx_1   = r_tail;
        rob_idx_2   = alloc_en_1 ? w_tail_p1 : r_tail;
        rt_flag_1   = r_rt_flag_1;
        rt_flag_2   = r_rt_flag_2;
        fp_i_1      = r_fp_i_1;
        fp_i_2      = r_fp_i_2;
        retire_cnt  = r_retire_cnt;
        count       = r_count;
    end

    // Control state: valid/done flags, pointers, count and retire outputs.
    // Update order matters: completions first, then retire clears, then
    // allocation writes, so a freshly allocated slot always starts not-done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rt_flag_1  <= 1'b0;
            r_rt_flag_2  <= 1'b0;
            r_fp_i_1     <= '0;
            r_fp_i_2     <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (cmpl_en_a && r_valid[cmpl_idx_a]) r_done[cmpl_idx_a] <= 1'b1;
            if (cmpl_en_b && r_valid[cmpl_idx_b]) r_done[cmpl_idx_b] <= 1'b1;
            if (w_r1) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
            if (w_r2) begin
                r_valid[w_head_p1] <= 1'b0;
                r_done[w_head_p1]  <= 1'b0;
            end
            if (w_acc1) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
            end
            if (w_acc2) begin
                r_valid[w_tail_p1] <= 1'b1;
                r_done[w_tail_p1]  <= 1'b0;
            end
            r_head       <= r_head + IDX_W'(w_r1) + IDX_W'(w_r2);
            r_tail       <= r_tail + IDX_W'(w_acc1) + IDX_W'(w_acc2);
            r_count      <= w_count_nxt;
            r_rt_flag_1  <= w_free1;
            r_rt_flag_2  <= w_free2;
            r_fp_i_1     <= w_free1 ? r_old_pd[r_head]    : '0;
            r_fp_i_2     <= w_free2 ? r_old_pd[w_head_p1] : '0;
            r_retire_cnt <= 2'(w_r1) + 2'(w_r2);
        end
    end

    // Entry payload capture on accepted allocation
    always_ff @(posedge clk) begin
        if (w_acc1) begin
            r_has_rd[r_tail] <= alloc_has_rd_1;
            r_pd[r_tail]     <= alloc_pd_1;
            r_old_pd[r_tail] <= alloc_old_pd_1;
        end
        if (w_acc2) begin
            r_has_rd[w_tail_p1] <= alloc_has_rd_2;
            r_pd[w_tail_p1]     <= alloc_pd_2;
            r_old_pd[w_tail_p1] <= alloc_old_pd_2;
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: scoreboard bench for the 2-wide retire stage.
// Allocated entries are pushed to an in-order queue; retire outputs pop and
// compare against it every cycle.
module tb_rob_retire;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int PREG_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_en_1, alloc_has_rd_1, alloc_en_2, alloc_has_rd_2;
    logic [PREG_W-1:0] alloc_pd_1, alloc_old_pd_1, alloc_pd_2, alloc_old_pd_2;
    logic              alloc_ready;
    logic [IDX_W-1:0]  rob_idx_1, rob_idx_2;
    logic              cmpl_en_a, cmpl_en_b;
    logic [IDX_W-1:0]  cmpl_idx_a, cmpl_idx_b;
    logic              rt_flag_1, rt_flag_2;
    logic [PREG_W-1:0] fp_i_1, fp_i_2;
    logic [1:0]        retire_cnt;
    logic [IDX_W:0]    count;

    always #5 clk = ~clk;

    rob_retire #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_en_1(alloc_en_1), .alloc_has_rd_1(alloc_has_rd_1),
        .alloc_pd_1(alloc_pd_1), .alloc_old_pd_1(alloc_old_pd_1),
        .alloc_en_2(alloc_en_2), .alloc_has_rd_2(alloc_has_rd_2),
        .alloc_pd_2(alloc_pd_2), .alloc_old_pd_2(alloc_old_pd_2),
        .alloc_ready(alloc_ready), .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2),
        .cmpl_en_a(cmpl_en_a), .cmpl_idx_a(cmpl_idx_a),
        .cmpl_en_b(cmpl_en_b), .cmpl_idx_b(cmpl_idx_b),
        .rt_flag_1(rt_flag_1), .fp_i_1(fp_i_1),
        .rt_flag_2(rt_flag_2), .fp_i_2(fp_i_2),
        .retire_cnt(retire_cnt), .count(count)
    );

    typedef struct packed {
        logic              has_rd;
        logic [PREG_W-1:0] old_pd;
    } ent_t;

    typedef struct {
        bit rst;
        bit a1; bit h1; int op1;
        bit a2; bit h2; int op2;
        bit ca; int ia;
        bit cb; int ib;
    } stim_t;

    // Reference model: in-order queue of live entries plus per-index done bits
    ent_t sb[$];
    bit   m_done[DEPTH];
    int   m_head = 0;

    logic              e_f1, e_f2, e_rdy;
    logic [PREG_W-1:0] e_p1, e_p2;
    logic [1:0]        e_rc;
    logic [IDX_W:0]    e_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int m_tail();
        return (m_head + sb.size()) % DEPTH;
    endfunction

    function automatic stim_t s_idle();
        stim_t s;
        s.rst = 0; s.a1 = 0; s.h1 = 0; s.op1 = 0; s.a2 = 0; s.h2 = 0; s.op2 = 0;
        s.ca = 0; s.ia = 0; s.cb = 0; s.ib = 0;
        return s;
    endfunction

    function automatic stim_t s_rst();
        stim_t s = s_idle();
        s.rst = 1;
        return s;
    endfunction

    function automatic stim_t s_al2(bit h1, int op1, bit h2, int op2);
        stim_t s = s_idle();
        s.a1 = 1; s.h1 = h1; s.op1 = op1;
        s.a2 = 1; s.h2 = h2; s.op2 = op2;
        return s;
    endfunction

    function automatic stim_t s_al1(bit h1, int op1);
        stim_t s = s_idle();
        s.a1 = 1; s.h1 = h1; s.op1 = op1;
        return s;
    endfunction

    function automatic stim_t s_cm(bit ca, int ia, bit cb, int ib);
        stim_t s = s_idle();
        s.ca = ca; s.ia = ia; s.cb = cb; s.ib = ib;
        return s;
    endfunction

    // Apply one cycle's inputs (new pd is old_pd+27, just distinct data)
    task automatic drive(input stim_t s);
        rst            = s.rst;
        alloc_en_1     = s.a1;
        alloc_has_rd_1 = s.h1;
        alloc_old_pd_1 = PREG_W'(s.op1);
        alloc_pd_1     = PREG_W'(s.op1 + 27);
        alloc_en_2     = s.a2;
        alloc_has_rd_2 = s.h2;
        alloc_old_pd_2 = PREG_W'(s.op2);
        alloc_pd_2     = PREG_W'(s.op2 + 27);
        cmpl_en_a      = s.ca;
        cmpl_idx_a     = IDX_W'(s.ia);
        cmpl_en_b      = s.cb;
        cmpl_idx_b     = IDX_W'(s.ib);
        #1;
    endtask

    // Advance the model over one edge using the driven inputs, then clock DUT
    task automatic tick();
        int   occ, tail, nret;
        bit   r1, r2, acc1, acc2;
        ent_t e;
        e_f1 = 1'b0; e_f2 = 1'b0; e_p1 = '0; e_p2 = '0; e_rc = '0;
        if (rst) begin
            sb.delete();
            m_head = 0;
            for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
        end else begin
            occ  = sb.size();
            tail = m_tail();
            acc1 = alloc_en_1 && (occ <= DEPTH - 2);
            acc2 = acc1 && alloc_en_2;
            r1   = (occ >= 1) && m_done[m_head];
            r2   = r1 && (occ >= 2) && m_done[(m_head + 1) % DEPTH];
            if (cmpl_en_a && ((int'(cmpl_idx_a) - m_head + DEPTH) % DEPTH) < occ)
                m_done[cmpl_idx_a] = 1'b1;
            if (cmpl_en_b && ((int'(cmpl_idx_b) - m_head + DEPTH) % DEPTH) < occ)
                m_done[cmpl_idx_b] = 1'b1;
            nret = int'(r1) + int'(r2);
            for (int k = 0; k < nret; k++) begin
                e = sb.pop_front();
                m_done[m_head] = 1'b0;
                m_head = (m_head + 1) % DEPTH;
                if (k == 0) begin
                    e_f1 = e.has_rd;
                    e_p1 = e.has_rd ? e.old_pd : '0;
                end else begin
                    e_f2 = e.has_rd;
                    e_p2 = e.has_rd ? e.old_pd : '0;
                end
            end
            e_rc = 2'(nret);
            if (acc1) begin
                e.has_rd = alloc_has_rd_1; e.old_pd = alloc_old_pd_1;
                sb.push_back(e);
                m_done[tail] = 1'b0;
            end
            if (acc2) begin
                e.has_rd = alloc_has_rd_2; e.old_pd = alloc_old_pd_2;
                sb.push_back(e);
                m_done[(tail + 1) % DEPTH] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        e_cnt = (IDX_W+1)'(sb.size());
        e_rdy = (sb.size() <= DEPTH - 2);
    endtask

    task automatic test_reset();
        stim_t q[$];
        q.push_back(s_rst());
        for (int i = 0; i < 5; i++) q.push_back(s_idle());
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            tick();
            n_checks++;
            if ({rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready} !==
                {e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy} || retire_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b want f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b",
                         i, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready,
                         e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy);
            end
        end
    endtask

    task automatic test_pair();
        stim_t q[$];
        stim_t s;
        s = s_al2(1, 5, 1, 6); s.ca = 1; s.ia = 0;  // same-edge completion: ignored
        q.push_back(s);
        q.push_back(s_cm(1, 1, 1, 1));              // both ports hit idx1
        q.push_back(s_idle());
        q.push_back(s_cm(1, 0, 0, 0));
        q.push_back(s_idle());
        q.push_back(s_idle());
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            if (q[i].a1) begin
                n_checks++;
                if (rob_idx_1 !== IDX_W'(m_tail()) || rob_idx_2 !== IDX_W'(m_tail() + 1)) begin
                    n_fail++;
                    $display("FAIL pair_idx[%0d]: got %0d/%0d want %0d/%0d", i, rob_idx_1, rob_idx_2,
                             m_tail(), (m_tail() + 1) % DEPTH);
                end
            end
            tick();
            n_checks++;
            if ({rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready} !==
                {e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy}) begin
                n_fail++;
                $display("FAIL pair[%0d]: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b want f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b",
                         i, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready,
                         e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy);
            end
            if (i == 4) begin
                n_checks++;
                if (rt_flag_1 !== 1'b1 || fp_i_1 !== 6'd5 || rt_flag_2 !== 1'b1 ||
                    fp_i_2 !== 6'd6 || retire_cnt !== 2'd2 || count !== 5'd0) begin
                    n_fail++;
                    $display("FAIL pair_retire: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d want 1/5/1/6/2/0",
                             rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count);
                end
            end
        end
    endtask

    task automatic test_no_rd();
        stim_t q[$];
        q.push_back(s_rst());
        q.push_back(s_al1(0, 9));
        q.push_back(s_cm(1, 0, 0, 0));
        q.push_back(s_idle());            // retires idx0, no preg freed
        q.push_back(s_al1(1, 12));        // lands at idx1: head advanced
        q.push_back(s_cm(0, 0, 1, 1));
        q.push_back(s_idle());
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            if (q[i].a1) begin
                n_checks++;
                if (rob_idx_1 !== IDX_W'(m_tail())) begin
                    n_fail++;
                    $display("FAIL nord_idx[%0d]: got %0d want %0d", i, rob_idx_1, m_tail());
                end
            end
            tick();
            n_checks++;
            if ({rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready} !==
                {e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy}) begin
                n_fail++;
                $display("FAIL nord[%0d]: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b want f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b",
                         i, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready,
                         e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy);
            end
        end
    endtask

    task automatic test_fill();
        stim_t q[$];
        int run, best;
        q.push_back(s_rst());
        for (int k = 0; k < 8; k++)
            q.push_back(s_al2((k % 5) != 3, 10 + 2 * k, 1'b1, 11 + 2 * k));
        q.push_back(s_al2(1, 60, 1, 61));   // full: must be ignored
        for (int k = 0; k < 8; k++) q.push_back(s_cm(1, 2 * k, 1, 2 * k + 1));
        q.push_back(s_idle());
        q.push_back(s_idle());
        run = 0; best = 0;
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            tick();
            n_checks++;
            if ({rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready} !==
                {e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy}) begin
                n_fail++;
                $display("FAIL fill[%0d]: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b want f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b",
                         i, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready,
                         e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy);
            end
            run  = (retire_cnt == 2'd2) ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        n_checks++;
        if (best != 8) begin
            n_fail++;
            $display("FAIL fill_drain_run: got %0d consecutive dual retires want 8", best);
        end
    endtask

    task automatic test_wrap();
        stim_t q[$];
        stim_t s;
        q.push_back(s_rst());
        // advance head/tail to 14 while overlapping alloc with retire
        for (int k = 0; k < 7; k++) begin
            s = s_al2(1, 20 + 2 * k, 1, 21 + 2 * k);
            if (k > 0) begin
                s.ca = 1; s.ia = 2 * k - 2; s.cb = 1; s.ib = 2 * k - 1;
            end
            q.push_back(s);
        end
        q.push_back(s_cm(1, 12, 1, 13));
        q.push_back(s_idle());
        q.push_back(s_al2(1, 40, 1, 41));   // idx 14/15
        q.push_back(s_al2(1, 42, 0, 43));   // idx 0/1
        q.push_back(s_cm(1, 1, 1, 0));      // younger done first: no retire
        q.push_back(s_cm(1, 15, 1, 14));
        for (int k = 0; k < 3; k++) q.push_back(s_idle());
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            if (q[i].a1) begin
                n_checks++;
                if (rob_idx_1 !== IDX_W'(m_tail()) || rob_idx_2 !== IDX_W'(m_tail() + 1)) begin
                    n_fail++;
                    $display("FAIL wrap_idx[%0d]: got %0d/%0d want %0d/%0d", i, rob_idx_1, rob_idx_2,
                             m_tail(), (m_tail() + 1) % DEPTH);
                end
            end
            tick();
            n_checks++;
            if ({rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready} !==
                {e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b want f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b",
                         i, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready,
                         e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        stim_t s;
        q.push_back(s_rst());
        q.push_back(s_al2(1, 1, 1, 2));
        q.push_back(s_al2(1, 3, 1, 4));
        q.push_back(s_al2(1, 5, 1, 6));
        q.push_back(s_cm(1, 3, 1, 5));
        q.push_back(s_cm(1, 0, 0, 0));      // 6 valid, 3 done, head ready to go
        s = s_al2(1, 7, 1, 8); s.rst = 1; s.ca = 1; s.ia = 1;
        q.push_back(s);                     // reset wins over everything
        q.push_back(s_cm(1, 2, 0, 0));      // stale completion
        q.push_back(s_al2(1, 7, 1, 8));
        q.push_back(s_al1(1, 9));
        q.push_back(s_cm(1, 0, 1, 1));
        q.push_back(s_idle());
        q.push_back(s_idle());
        q.push_back(s_cm(0, 0, 1, 2));
        q.push_back(s_idle());
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            tick();
            n_checks++;
            if ({rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready} !==
                {e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy}) begin
                n_fail++;
                $display("FAIL rstmid[%0d]: got f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b want f1=%b fp1=%0d f2=%b fp2=%0d rc=%0d cnt=%0d rdy=%b",
                         i, rt_flag_1, fp_i_1, rt_flag_2, fp_i_2, retire_cnt, count, alloc_ready,
                         e_f1, e_p1, e_f2, e_p2, e_rc, e_cnt, e_rdy);
            end
        end
    endtask

    initial begin
        drive(s_idle());
        test_reset();
        test_pair();
        test_no_rd();
        test_fill();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
